// File: rtl/ledr_pkg.sv
// Shared constants for the LEDR PWM dimmer: register map, CTRL bit positions, gamma curve.
// Purely combinational helpers; no state, no flow control.
// The gamma helper is only referenced when LEDR_PWM_GAMMA_EN is defined.
package ledr_pkg;

    localparam logic [1:0] ADDR_BRIGHT     = 2'd0;
    localparam logic [1:0] ADDR_BLINK_MASK = 2'd1;
    localparam logic [1:0] ADDR_BLINK_RATE = 2'd2;
    localparam logic [1:0] ADDR_CTRL       = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_PHASE_BIT  = 1;

    // Gamma 2.2 approximated as 0.8*x^2 + 0.2*x^3 on the normalised range, rounded.
    // Exact at both ends (0 -> 0, max -> max) and within about 1% of x^2.2 elsewhere.
    function automatic logic [31:0] gamma_lut(input logic [31:0] x, input int bits);
        longint m;
        longint xv;
        longint num;
        longint den;
        m   = (longint'(1) << bits) - 1;
        xv  = longint'(x) & m;
        num = 4 * xv * xv * m + xv * xv * xv;
        den = 5 * m * m;
        return 32'((num + den / 2) / den);
    endfunction

endpackage

// File: rtl/ledr_pwm_dimmer_if.sv
// Avalon-MM slave port of the dimmer: word address, select, active-low write, write/read data.
// Reads are combinational from address; writes take effect on the clock edge they are sampled.
interface ledr_pwm_dimmer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/ledr_pwm_timebase.sv
// PWM timebase: prescaler, PWM counter, frame wrap detect and per-frame duty latch (gamma when LEDR_PWM_GAMMA_EN).
// pwm_on is combinational from registered state; frame_tick follows the wrap by 1 clk.
// Free-running, no backpressure.
module ledr_pwm_timebase
    import ledr_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 195
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] bright,
    output logic                pwm_on,
    output logic                frame_wrap,
    output logic                frame_tick
);

    localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty_act;
    logic [PWM_BITS-1:0] duty_next;
    logic                step;

    assign step       = (presc == PS_LAST);
    assign frame_wrap = step && (pwm_cnt == CNT_MAX);

`ifdef LEDR_PWM_GAMMA_EN
    assign duty_next = PWM_BITS'(gamma_lut(32'(bright), PWM_BITS));
`else
    assign duty_next = bright;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc      <= '0;
            pwm_cnt    <= '0;
            duty_act   <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_wrap;
            if (step) begin
                presc   <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                presc   <= presc + 1'b1;
            end
            // Duty only changes on the frame boundary so a frame is never cut short.
            if (frame_wrap) begin
                duty_act <= duty_next;
            end
        end
    end

    assign pwm_on = (duty_act == CNT_MAX) ? 1'b1 : (pwm_cnt < duty_act);

endmodule

// File: rtl/ledr_pwm_dimmer.sv
// LEDR output stage: PWM brightness, per-LED blink mask and master enable behind a 4-register Avalon slave.
// pattern_in -> led_out latency 2 clk; register writes are single-cycle, reads combinational.
// No backpressure. Optional gamma mapping of BRIGHT under LEDR_PWM_GAMMA_EN.
module ledr_pwm_dimmer
    import ledr_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 195
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   pattern_in,
    ledr_pwm_dimmer_if.slave   bus,
    output logic [WIDTH-1:0]   led_out,
    output logic               frame_tick
);

    logic [PWM_BITS-1:0] bright;
    logic [WIDTH-1:0]    blink_mask;
    logic [15:0]         blink_rate;
    logic [15:0]         blink_cnt;
    logic                blink_phase;
    logic                enable;
    logic                wr_en;
    logic                pwm_on;
    logic                frame_wrap;
    logic [WIDTH-1:0]    pat_q;
    logic [WIDTH-1:0]    blink_kill;

    assign wr_en = bus.chipselect && !bus.write_n;

    ledr_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk        (clk),
        .reset_n    (reset_n),
        .bright     (bright),
        .pwm_on     (pwm_on),
        .frame_wrap (frame_wrap),
        .frame_tick (frame_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright     <= '1;
            blink_mask <= '0;
            blink_rate <= '0;
            enable     <= 1'b1;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_BRIGHT:     bright     <= bus.writedata[PWM_BITS-1:0];
                ADDR_BLINK_MASK: blink_mask <= bus.writedata[WIDTH-1:0];
                ADDR_BLINK_RATE: blink_rate <= bus.writedata[15:0];
                default:         enable     <= bus.writedata[CTRL_ENABLE_BIT];
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_BRIGHT:     bus.readdata[PWM_BITS-1:0] = bright;
            ADDR_BLINK_MASK: bus.readdata[WIDTH-1:0]    = blink_mask;
            ADDR_BLINK_RATE: bus.readdata[15:0]         = blink_rate;
            default: begin
                bus.readdata[CTRL_ENABLE_BIT] = enable;
                bus.readdata[CTRL_PHASE_BIT]  = blink_phase;
            end
        endcase
    end

    // A rate write restarts the frame count but leaves the phase alone; rate 0 freezes both.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wr_en && (bus.address == ADDR_BLINK_RATE)) begin
            blink_cnt <= '0;
        end else if (frame_wrap && (blink_rate != 16'd0)) begin
            if (blink_cnt == blink_rate - 16'd1) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    assign blink_kill = blink_mask & {WIDTH{blink_phase}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q   <= '0;
            led_out <= '0;
        end else begin
            pat_q   <= pattern_in;
            led_out <= {WIDTH{enable & pwm_on}} & pat_q & ~blink_kill;
        end
    end

endmodule

// File: tb/tb_ledr_pwm_dimmer.sv
// Directed bench for ledr_pwm_dimmer with PRESCALE=2 (512 clk per PWM frame).
module tb_ledr_pwm_dimmer;

    localparam int WIDTH    = 16;
    localparam int PWM_BITS = 8;
    localparam int PRESCALE = 2;
    localparam int FRAME    = 256 * PRESCALE;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] pattern_in;
    logic [WIDTH-1:0] led_out;
    logic             frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    ledr_pwm_dimmer_if bus ();

    ledr_pwm_dimmer #(
        .WIDTH    (WIDTH),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pattern_in (pattern_in),
        .bus        (bus.slave),
        .led_out    (led_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.address    = a;
        bus.chipselect = 1'b1;
        #1;
        check(tag, bus.readdata, exp);
        bus.chipselect = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge clk);
            seen = frame_tick;
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    // Counts samples until the next frame_tick (inclusive); tick_at = 0 if none arrived.
    task automatic measure_frame(input logic [WIDTH-1:0] ref_v, output int on_cnt,
                                 output int nz_cnt, output int tick_at);
        on_cnt  = 0;
        nz_cnt  = 0;
        tick_at = 0;
        for (int i = 1; i <= FRAME + 64 && tick_at == 0; i++) begin
            @(negedge clk);
            if (led_out == ref_v) on_cnt++;
            if (led_out != '0) nz_cnt++;
            if (frame_tick) tick_at = i;
        end
    endtask

    // Checks the first frame after a reset release: 2 clk latency, then continuously lit.
    task automatic check_post_reset(input string tag, input logic [WIDTH-1:0] pat);
        int lit;
        @(negedge clk);
        check({tag, "_lat1"}, led_out, '0);
        @(negedge clk);
        check({tag, "_lat2"}, led_out, pat);
        lit = 0;
        for (int i = 0; i < FRAME - 2; i++) begin
            @(negedge clk);
            if (led_out == pat) lit++;
        end
        check({tag, "_frame_lit"}, lit, FRAME - 2);
        check({tag, "_first_tick"}, frame_tick, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int on, nz, tk;
        logic [31:0] exp_ctrl [4];
        logic [15:0] exp_led  [4];

        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        pattern_in     = 16'hA5A5;
        reset_n        = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_led", led_out, '0);
        check("rst_tick", frame_tick, 1'b0);
        bus_rd("rst_bright", 2'd0, 32'hFF);
        bus_rd("rst_mask",   2'd1, 32'h0);
        bus_rd("rst_rate",   2'd2, 32'h0);
        bus_rd("rst_ctrl",   2'd3, 32'h1);
        reset_n = 1'b1;
        check_post_reset("boot", 16'hA5A5);

        measure_frame(16'hA5A5, on, nz, tk);
        check("full_on_cnt", on, FRAME);
        check("full_tick_at", tk, FRAME);

        // BRIGHT=64 written mid-frame: rest of this frame still fully lit
        pattern_in = 16'hFFFF;
        repeat (100) @(negedge clk);
        bus_wr(2'd0, 32'hABCD_0040);
        bus_rd("bright_trunc", 2'd0, 32'h40);
        measure_frame(16'hFFFF, on, nz, tk);
        check("midwr_frame_len", tk, 410);
        check("midwr_still_lit", on, tk);
        measure_frame(16'hFFFF, on, nz, tk);
        check("b64_on", on, 64 * PRESCALE);
        check("b64_nz", nz, 64 * PRESCALE);
        check("b64_tick_at", tk, FRAME);

        repeat (50) @(negedge clk);
        bus_wr(2'd0, 32'h0);
        wait_tick("b0_tick_timeout");
        measure_frame(16'hFFFF, on, nz, tk);
        check("b0_on", on, 0);
        check("b0_nz", nz, 0);

`ifdef LEDR_PWM_GAMMA_EN
        bus_wr(2'd0, 32'd128);
        wait_tick("gamma_tick_timeout");
        measure_frame(16'hFFFF, on, nz, tk);
        check("gamma_on", on, 58 * PRESCALE);
        bus_rd("gamma_readback", 2'd0, 32'd128);
`endif

        // Blink every 2 frames on bits[3:0]
        bus_wr(2'd0, 32'hFF);
        wait_tick("blink_bright_timeout");
        repeat (20) @(negedge clk);
        bus_wr(2'd1, 32'hFFFF_000F);
        bus_rd("mask_trunc", 2'd1, 32'hF);
        bus_wr(2'd2, 32'd2);
        wait_tick("blink_start_timeout");
        exp_ctrl = '{32'd1, 32'd3, 32'd3, 32'd1};
        exp_led  = '{16'hFFFF, 16'hFFF0, 16'hFFF0, 16'hFFFF};
        for (int f = 0; f < 4; f++) begin
            bus_rd($sformatf("blink_ctrl%0d", f), 2'd3, exp_ctrl[f]);
            measure_frame(exp_led[f], on, nz, tk);
            check($sformatf("blink_on%0d", f), on, FRAME);
            check($sformatf("blink_tick%0d", f), tk, FRAME);
        end

        // Freeze with phase = 1
        wait_tick("freeze_tick_timeout");
        bus_rd("freeze_ctrl_pre", 2'd3, 32'd3);
        repeat (10) @(negedge clk);
        bus_wr(2'd2, 32'd0);
        wait_tick("freeze_start_timeout");
        for (int f = 0; f < 2; f++) begin
            measure_frame(16'hFFF0, on, nz, tk);
            check($sformatf("freeze_on%0d", f), on, FRAME);
            bus_rd($sformatf("freeze_ctrl%0d", f), 2'd3, 32'd3);
        end

        // Master enable
        bus_wr(2'd1, 32'h0);
        repeat (3) @(negedge clk);
        check("unmask_led", led_out, 16'hFFFF);
        bus_wr(2'd3, 32'h0);
        check("en_off_cyc1", led_out, 16'hFFFF);
        @(negedge clk);
        check("en_off_cyc2", led_out, 16'h0);
        bus_rd("en_off_ctrl", 2'd3, 32'd2);
        wait_tick("en_off_tick_timeout");
        measure_frame(16'hFFFF, on, nz, tk);
        check("en_off_nz", nz, 0);
        check("en_off_tick_at", tk, FRAME);
        bus_wr(2'd3, 32'h1);
        check("en_on_cyc1", led_out, 16'h0);
        @(negedge clk);
        check("en_on_cyc2", led_out, 16'hFFFF);

        // Reset mid-frame with BRIGHT=10
        bus_wr(2'd0, 32'd10);
        wait_tick("rst_mid_tick_timeout");
        repeat (5) @(negedge clk);
        check("pre_rst_lit", led_out, 16'hFFFF);
        reset_n = 1'b0;
        #1;
        check("mid_rst_led", led_out, '0);
        check("mid_rst_tick", frame_tick, 1'b0);
        @(negedge clk);
        bus_rd("mid_rst_bright", 2'd0, 32'hFF);
        bus_rd("mid_rst_ctrl",   2'd3, 32'h1);
        reset_n = 1'b1;
        check_post_reset("rerun", 16'hFFFF);
        measure_frame(16'hFFFF, on, nz, tk);
        check("rerun_on", on, FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
